// File: rtl/trig_ack_monitor_pkg.sv
// Shared definitions for the SCROD trigger/ack monitor: FSM state type,
// default channel count and a population-count helper.
package trig_pkg;

    localparam int N_SCRODS_DEF = 12;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Number of set bits in a vector of up to 64 channels.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/trig_ack_monitor_if.sv
// Trigger/ack bundle between the trigger logic (master) and the ack monitor
// (slave). Clock and reset are kept as plain ports on the monitor.
interface trig_ack_monitor_if
    import trig_pkg::*;
#(
    parameter int N_SCRODS = N_SCRODS_DEF,
    parameter int TMO_W    = 8,
    parameter int MISS_W   = 16
);
    logic [N_SCRODS-1:0] ACK;
    logic                TRG_FIRE;
    logic [N_SCRODS-1:0] TRG_MASK;
    logic [TMO_W-1:0]    TMO_CYCLES;
    logic                CLEAR_STATS;

    logic [N_SCRODS-1:0] ACK_SYNC;
    logic [N_SCRODS-1:0] ACK_RISE;
    logic                BUSY;
    logic                ALL_ACKED;
    logic [TMO_W-1:0]    LAST_LATENCY;
    logic [N_SCRODS-1:0] TMO_FLAGS;
    logic [MISS_W-1:0]   MISS_COUNT;
    logic                OVERLAP;

    modport master (
        output ACK, TRG_FIRE, TRG_MASK, TMO_CYCLES, CLEAR_STATS,
        input  ACK_SYNC, ACK_RISE, BUSY, ALL_ACKED, LAST_LATENCY,
               TMO_FLAGS, MISS_COUNT, OVERLAP
    );

    modport slave (
        input  ACK, TRG_FIRE, TRG_MASK, TMO_CYCLES, CLEAR_STATS,
        output ACK_SYNC, ACK_RISE, BUSY, ALL_ACKED, LAST_LATENCY,
               TMO_FLAGS, MISS_COUNT, OVERLAP
    );
endinterface

// File: rtl/trig_ack_monitor_ack_sync_edge.sv
// One ACK channel: two-flop synchroniser followed by a registered
// rising-edge detector. sync lags d by 2 cycles, rise pulses 3 cycles
// after the d edge for exactly one cycle.
module ack_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise
);
    logic meta_p0;
    logic sync_p1;
    logic sync_p2;
    logic rise_q;

    // Synchroniser chain, delayed copy and registered edge pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
            sync_p2 <= sync_p1;
            rise_q  <= sync_p1 & ~sync_p2;
        end
    end

    assign sync = sync_p1;
    assign rise = rise_q;

endmodule

// File: rtl/trig_ack_monitor.sv
// Trigger acknowledge monitor: synchronises SCROD ACK lines, opens an ack
// window on each trigger, and reports completion, latency, per-channel
// timeouts, a saturating miss counter and trigger overlap.
module trig_ack_monitor
    import trig_pkg::*;
#(
    parameter int N_SCRODS = N_SCRODS_DEF,  // at most 64 (popcount width)
    parameter int TMO_W    = 8,
    parameter int MISS_W   = 16
) (
    input logic               CLK_80MHZ,
    input logic               RESET_N,
    trig_ack_monitor_if.slave bus
);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
    localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

    logic [N_SCRODS-1:0] ack_sync;
    logic [N_SCRODS-1:0] ack_rise;

    state_t              state_q, state_d;
    logic [N_SCRODS-1:0] pending_q, pending_d, pending_n;
    logic [TMO_W-1:0]    timer_q, timer_d;
    logic                ack_done;
    logic                tmo_hit;
    logic                start_empty;

    logic                all_acked_q;
    logic [TMO_W-1:0]    last_latency_q;
    logic [N_SCRODS-1:0] tmo_flags_q;
    logic [MISS_W-1:0]   miss_count_q;
    logic                overlap_q;

    for (genvar i = 0; i < N_SCRODS; i++) begin : g_ack
        ack_sync_edge u_sync (
            .clk   (CLK_80MHZ),
            .rst_n (RESET_N),
            .d     (bus.ACK[i]),
            .sync  (ack_sync[i]),
            .rise  (ack_rise[i])
        );
    end

    // FSM state, pending set and window timer registers.
    always_ff @(posedge CLK_80MHZ) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            pending_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
        end
    end

    // Next-state logic: window open, ack collection and end-of-window
    // decision; an ack arriving on the timeout cycle takes priority.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        timer_d     = timer_q;
        pending_n   = pending_q & ~ack_rise;
        ack_done    = 1'b0;
        tmo_hit     = 1'b0;
        start_empty = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.TRG_FIRE) begin
                    pending_d = bus.TRG_MASK;
                    timer_d   = '0;
                    if (bus.TRG_MASK == '0) begin
                        start_empty = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                pending_d = pending_n;
                if (timer_q != '1) begin
                    timer_d = timer_q + TMO_ONE;
                end
                if (popcount(64'(pending_n)) == 0) begin
                    ack_done = 1'b1;
                    state_d  = IDLE;
                end else if ((bus.TMO_CYCLES != '0) &&
                             (timer_q == bus.TMO_CYCLES - TMO_ONE)) begin
                    tmo_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion pulse, latency capture and sticky statistics; a clear
    // request overrides any timeout or overlap update in the same cycle.
    always_ff @(posedge CLK_80MHZ) begin
        if (!RESET_N) begin
            all_acked_q    <= 1'b0;
            last_latency_q <= '0;
            tmo_flags_q    <= '0;
            miss_count_q   <= '0;
            overlap_q      <= 1'b0;
        end else begin
            all_acked_q <= ack_done | start_empty;
            if (ack_done) begin
                last_latency_q <= timer_q;
            end else if (start_empty) begin
                last_latency_q <= '0;
            end
            if (bus.CLEAR_STATS) begin
                tmo_flags_q  <= '0;
                miss_count_q <= '0;
                overlap_q    <= 1'b0;
            end else begin
                if (tmo_hit) begin
                    tmo_flags_q <= tmo_flags_q | pending_n;
                    if (miss_count_q != '1) begin
                        miss_count_q <= miss_count_q + MISS_ONE;
                    end
                end
                if ((state_q == WAIT) && bus.TRG_FIRE) begin
                    overlap_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ACK_SYNC     = ack_sync;
    assign bus.ACK_RISE     = ack_rise;
    assign bus.BUSY         = (state_q == WAIT);
    assign bus.ALL_ACKED    = all_acked_q;
    assign bus.LAST_LATENCY = last_latency_q;
    assign bus.TMO_FLAGS    = tmo_flags_q;
    assign bus.MISS_COUNT   = miss_count_q;
    assign bus.OVERLAP      = overlap_q;

endmodule

// File: tb/tb_trig_ack_monitor.sv
// Directed bench for trig_ack_monitor. A second instance with a 4-bit miss
// counter shares the same stimulus so saturation is reachable quickly.
module tb_trig_ack_monitor;
    import trig_pkg::*;

    localparam int N  = 12;
    localparam int TW = 8;
    localparam int MW = 16;
    localparam int MS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trig_ack_monitor_if #(.N_SCRODS(N), .TMO_W(TW), .MISS_W(MW)) mon_if ();
    trig_ack_monitor_if #(.N_SCRODS(N), .TMO_W(TW), .MISS_W(MS)) sat_if ();

    assign sat_if.ACK         = mon_if.ACK;
    assign sat_if.TRG_FIRE    = mon_if.TRG_FIRE;
    assign sat_if.TRG_MASK    = mon_if.TRG_MASK;
    assign sat_if.TMO_CYCLES  = mon_if.TMO_CYCLES;
    assign sat_if.CLEAR_STATS = mon_if.CLEAR_STATS;

    trig_ack_monitor #(.N_SCRODS(N), .TMO_W(TW), .MISS_W(MW)) dut (
        .CLK_80MHZ (clk),
        .RESET_N   (rst_n),
        .bus       (mon_if)
    );

    trig_ack_monitor #(.N_SCRODS(N), .TMO_W(TW), .MISS_W(MS)) dut_sat (
        .CLK_80MHZ (clk),
        .RESET_N   (rst_n),
        .bus       (sat_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire_window(input logic [N-1:0] mask, input logic [TW-1:0] tmo);
        mon_if.TMO_CYCLES = tmo;
        mon_if.TRG_MASK   = mask;
        mon_if.TRG_FIRE   = 1'b1;
        tick();
        mon_if.TRG_FIRE   = 1'b0;
    endtask

    task automatic settle_ack();
        mon_if.ACK = '0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mon_if.ACK = 12'hFFF;
        repeat (4) tick();
        total++; if (mon_if.ACK_SYNC !== 12'h000) begin bad++; $display("FAIL rst_ack_sync got=%h exp=000", mon_if.ACK_SYNC); end
        total++; if (mon_if.ACK_RISE !== 12'h000) begin bad++; $display("FAIL rst_ack_rise got=%h exp=000", mon_if.ACK_RISE); end
        total++; if (mon_if.BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", mon_if.BUSY); end
        total++; if (mon_if.ALL_ACKED !== 1'b0) begin bad++; $display("FAIL rst_all_acked got=%b exp=0", mon_if.ALL_ACKED); end
        total++; if (mon_if.LAST_LATENCY !== 8'd0) begin bad++; $display("FAIL rst_latency got=%0d exp=0", mon_if.LAST_LATENCY); end
        total++; if (mon_if.TMO_FLAGS !== 12'h000) begin bad++; $display("FAIL rst_tmo_flags got=%h exp=000", mon_if.TMO_FLAGS); end
        total++; if (mon_if.MISS_COUNT !== 16'd0) begin bad++; $display("FAIL rst_miss got=%0d exp=0", mon_if.MISS_COUNT); end
        total++; if (mon_if.OVERLAP !== 1'b0) begin bad++; $display("FAIL rst_overlap got=%b exp=0", mon_if.OVERLAP); end
        rst_n = 1'b1;
        tick();
        total++; if (mon_if.ACK_SYNC !== 12'h000) begin bad++; $display("FAIL sync_lag1 got=%h exp=000", mon_if.ACK_SYNC); end
        tick();
        total++; if (mon_if.ACK_SYNC !== 12'hFFF) begin bad++; $display("FAIL sync_lag2 got=%h exp=fff", mon_if.ACK_SYNC); end
        total++; if (mon_if.ACK_RISE !== 12'h000) begin bad++; $display("FAIL rise_early got=%h exp=000", mon_if.ACK_RISE); end
        tick();
        total++; if (mon_if.ACK_RISE !== 12'hFFF) begin bad++; $display("FAIL rise_pulse got=%h exp=fff", mon_if.ACK_RISE); end
        tick();
        total++; if (mon_if.ACK_RISE !== 12'h000) begin bad++; $display("FAIL rise_one_cycle got=%h exp=000", mon_if.ACK_RISE); end
        settle_ack();
    endtask

    task automatic test_all_ack();
        int pulses;
        int at;
        pulses = 0;
        at = -1;
        fire_window(12'h00F, 8'd20);
        for (int k = 0; k < 20; k++) begin
            if (k == 2 || k == 4 || k == 6 || k == 8) mon_if.ACK[k/2-1] = 1'b1;
            if (mon_if.ALL_ACKED === 1'b1) begin pulses++; at = k; end
            if (k == 11) begin
                total++; if (mon_if.BUSY !== 1'b1) begin bad++; $display("FAIL allack_busy got=%b exp=1", mon_if.BUSY); end
            end
            tick();
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL allack_pulses got=%0d exp=1", pulses); end
        total++; if (at != 12) begin bad++; $display("FAIL allack_cycle got=%0d exp=12", at); end
        total++; if (mon_if.LAST_LATENCY !== 8'd11) begin bad++; $display("FAIL allack_latency got=%0d exp=11", mon_if.LAST_LATENCY); end
        total++; if (mon_if.TMO_FLAGS !== 12'h000) begin bad++; $display("FAIL allack_flags got=%h exp=000", mon_if.TMO_FLAGS); end
        total++; if (mon_if.BUSY !== 1'b0) begin bad++; $display("FAIL allack_idle got=%b exp=0", mon_if.BUSY); end
        settle_ack();
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        fire_window(12'h003, 8'd10);
        for (int k = 0; k < 15; k++) begin
            if (k == 1) mon_if.ACK[0] = 1'b1;
            if (mon_if.ALL_ACKED === 1'b1) pulses++;
            if (k == 9) begin
                total++; if (mon_if.BUSY !== 1'b1) begin bad++; $display("FAIL tmo_busy_last got=%b exp=1", mon_if.BUSY); end
            end
            if (k == 10) begin
                total++; if (mon_if.BUSY !== 1'b0) begin bad++; $display("FAIL tmo_busy_drop got=%b exp=0", mon_if.BUSY); end
            end
            tick();
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL tmo_no_allack got=%0d exp=0", pulses); end
        total++; if (mon_if.TMO_FLAGS !== 12'h002) begin bad++; $display("FAIL tmo_flags got=%h exp=002", mon_if.TMO_FLAGS); end
        total++; if (mon_if.MISS_COUNT !== 16'd1) begin bad++; $display("FAIL tmo_miss got=%0d exp=1", mon_if.MISS_COUNT); end
        settle_ack();
    endtask

    task automatic test_edge_cases();
        int drops;
        int pulses;
        fire_window(12'h000, 8'd20);
        total++; if (mon_if.ALL_ACKED !== 1'b1) begin bad++; $display("FAIL empty_allack got=%b exp=1", mon_if.ALL_ACKED); end
        total++; if (mon_if.LAST_LATENCY !== 8'd0) begin bad++; $display("FAIL empty_latency got=%0d exp=0", mon_if.LAST_LATENCY); end
        total++; if (mon_if.BUSY !== 1'b0) begin bad++; $display("FAIL empty_busy got=%b exp=0", mon_if.BUSY); end
        tick();
        total++; if (mon_if.ALL_ACKED !== 1'b0) begin bad++; $display("FAIL empty_pulse_len got=%b exp=0", mon_if.ALL_ACKED); end
        drops = 0;
        fire_window(12'h001, 8'd0);
        repeat (1000) begin
            if (mon_if.BUSY !== 1'b1) drops++;
            tick();
        end
        total++; if (drops != 0) begin bad++; $display("FAIL notmo_busy_drops got=%0d exp=0", drops); end
        pulses = 0;
        mon_if.ACK[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (mon_if.ALL_ACKED === 1'b1) pulses++;
            tick();
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL notmo_allack got=%0d exp=1", pulses); end
        total++; if (mon_if.LAST_LATENCY !== 8'd255) begin bad++; $display("FAIL notmo_latency_sat got=%0d exp=255", mon_if.LAST_LATENCY); end
        settle_ack();
    endtask

    task automatic test_overlap();
        int pulses;
        int at;
        pulses = 0;
        at = -1;
        fire_window(12'h001, 8'd20);
        for (int k = 0; k < 12; k++) begin
            if (k == 2) mon_if.TRG_FIRE = 1'b1;
            if (k == 3) begin mon_if.TRG_FIRE = 1'b0; mon_if.ACK[0] = 1'b1; end
            if (mon_if.ALL_ACKED === 1'b1) begin pulses++; at = k; end
            tick();
        end
        total++; if (mon_if.OVERLAP !== 1'b1) begin bad++; $display("FAIL ovl_flag got=%b exp=1", mon_if.OVERLAP); end
        total++; if (pulses != 1 || at != 7) begin bad++; $display("FAIL ovl_allack got=%0d@%0d exp=1@7", pulses, at); end
        total++; if (mon_if.LAST_LATENCY !== 8'd6) begin bad++; $display("FAIL ovl_latency got=%0d exp=6", mon_if.LAST_LATENCY); end
        total++; if (mon_if.BUSY !== 1'b0) begin bad++; $display("FAIL ovl_busy got=%b exp=0", mon_if.BUSY); end
        settle_ack();
    endtask

    task automatic test_race();
        int pulses;
        int at;
        pulses = 0;
        at = -1;
        fire_window(12'h001, 8'd10);
        for (int k = 0; k < 14; k++) begin
            if (k == 6) mon_if.ACK[0] = 1'b1;
            if (k == 9) mon_if.TRG_FIRE = 1'b1;
            if (k == 10) mon_if.TRG_FIRE = 1'b0;
            if (mon_if.ALL_ACKED === 1'b1) begin pulses++; at = k; end
            if (k == 11) begin
                total++; if (mon_if.BUSY !== 1'b0) begin bad++; $display("FAIL race_no_new_window got=%b exp=0", mon_if.BUSY); end
            end
            tick();
        end
        total++; if (pulses != 1 || at != 10) begin bad++; $display("FAIL race_allack got=%0d@%0d exp=1@10", pulses, at); end
        total++; if (mon_if.LAST_LATENCY !== 8'd9) begin bad++; $display("FAIL race_latency got=%0d exp=9", mon_if.LAST_LATENCY); end
        total++; if (mon_if.TMO_FLAGS !== 12'h002) begin bad++; $display("FAIL race_flags got=%h exp=002", mon_if.TMO_FLAGS); end
        total++; if (mon_if.MISS_COUNT !== 16'd1) begin bad++; $display("FAIL race_miss got=%0d exp=1", mon_if.MISS_COUNT); end
        settle_ack();
    endtask

    task automatic test_sat_clear();
        mon_if.CLEAR_STATS = 1'b1;
        tick();
        mon_if.CLEAR_STATS = 1'b0;
        total++; if (mon_if.MISS_COUNT !== 16'd0) begin bad++; $display("FAIL clr_miss got=%0d exp=0", mon_if.MISS_COUNT); end
        total++; if (mon_if.TMO_FLAGS !== 12'h000) begin bad++; $display("FAIL clr_flags got=%h exp=000", mon_if.TMO_FLAGS); end
        total++; if (mon_if.OVERLAP !== 1'b0) begin bad++; $display("FAIL clr_overlap got=%b exp=0", mon_if.OVERLAP); end
        repeat (19) begin
            fire_window(12'h001, 8'd1);
            tick();
        end
        total++; if (mon_if.MISS_COUNT !== 16'd19) begin bad++; $display("FAIL sat_main_count got=%0d exp=19", mon_if.MISS_COUNT); end
        total++; if (mon_if.TMO_FLAGS !== 12'h001) begin bad++; $display("FAIL sat_flags got=%h exp=001", mon_if.TMO_FLAGS); end
        total++; if (sat_if.MISS_COUNT !== 4'hF) begin bad++; $display("FAIL sat_small_count got=%h exp=f", sat_if.MISS_COUNT); end
        fire_window(12'h001, 8'd1);
        mon_if.CLEAR_STATS = 1'b1;
        tick();
        mon_if.CLEAR_STATS = 1'b0;
        total++; if (mon_if.MISS_COUNT !== 16'd0) begin bad++; $display("FAIL clr_race_miss got=%0d exp=0", mon_if.MISS_COUNT); end
        total++; if (mon_if.TMO_FLAGS !== 12'h000) begin bad++; $display("FAIL clr_race_flags got=%h exp=000", mon_if.TMO_FLAGS); end
        total++; if (mon_if.BUSY !== 1'b0) begin bad++; $display("FAIL clr_race_busy got=%b exp=0", mon_if.BUSY); end
        tick();
        total++; if (sat_if.MISS_COUNT !== 4'h0) begin bad++; $display("FAIL clr_race_lost got=%h exp=0", sat_if.MISS_COUNT); end
    endtask

    initial begin
        mon_if.ACK         = '0;
        mon_if.TRG_FIRE    = 1'b0;
        mon_if.TRG_MASK    = '0;
        mon_if.TMO_CYCLES  = '0;
        mon_if.CLEAR_STATS = 1'b0;
        test_reset();
        test_all_ack();
        test_timeout();
        test_edge_cases();
        test_overlap();
        test_race();
        test_sat_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
